// File: rtl/downcounter_sync.sv
// Loadable WIDTH-bit down counter with enable and combinational terminal count.
// Define DOWNCOUNTER_SYNC_SATURATE_EN to make the count stick at zero instead of wrapping.
module downcounter_sync #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned LOAD_VAL = (64'd1 << WIDTH) - 64'd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LOAD_Q = LOAD_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] q_next;
   logic             at_zero;

   assign at_zero = (q == '0);
   assign tc      = at_zero & en;

   // NOTE: q_next gets a default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      q_next = q;
      if (ld) begin
         q_next = LOAD_Q;
      end else if (en) begin
`ifdef DOWNCOUNTER_SYNC_SATURATE_EN
         if (!at_zero) q_next = q - WIDTH'(1);
`else
         q_next = q - WIDTH'(1);
`endif
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= q_next;
   end

endmodule

// File: tb/tb_downcounter_sync.sv
// Self-checking bench for downcounter_sync at default parameters (WIDTH=4, LOAD_VAL=15).
// Honours DOWNCOUNTER_SYNC_SATURATE_EN so the same bench covers both builds.
module tb_downcounter_sync;

   localparam int WIDTH    = 4;
   localparam int MODULUS  = 16;
   localparam int LOAD_VAL = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ld  = 1'b0;
   logic             en  = 1'b0;
   logic [WIDTH-1:0] q;
   logic             tc;

   int checks = 0;
   int errors = 0;
   int m_q    = 0;  // reference count as a plain integer

   downcounter_sync dut (
      .clk (clk),
      .rst (rst),
      .ld  (ld),
      .en  (en),
      .q   (q),
      .tc  (tc)
   );

   always #5 clk = ~clk;

   function automatic int model_dec(input int v);
`ifdef DOWNCOUNTER_SYNC_SATURATE_EN
      return (v == 0) ? 0 : v - 1;
`else
      return (v + MODULUS - 1) % MODULUS;
`endif
   endfunction

   function automatic logic model_tc(input int v, input logic e);
      return (v == 0) && e;
   endfunction

   // Apply inputs, take one rising edge, advance the model, settle 1 time unit past the edge.
   task automatic tick(input logic l, input logic e);
      ld = l;
      en = e;
      @(posedge clk);
      if (!rst)   m_q = 0;
      else if (l) m_q = LOAD_VAL;
      else if (e) m_q = model_dec(m_q);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
      en = 1'b1; #1;
      checks++;
      if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_en: got %b want 1", tc); end
      @(posedge clk); #1;
      rst = 1'b1;
      m_q = 0;
      en  = 1'b0;
   endtask

   task automatic test_load();
      tick(1'b1, 1'b0);
      checks++;
      if (q !== 4'b1111) begin errors++; $display("FAIL load: got %b want 1111", q); end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         checks++;
         if (q !== 4'b1111) begin errors++; $display("FAIL hold_%0d: got %b want 1111", i, q); end
      end
   endtask

   task automatic test_load_priority();
      tick(1'b0, 1'b1);  // move off LOAD_VAL so a lost load would show
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1);
         checks++;
         if (q !== 4'b1111) begin errors++; $display("FAIL load_priority_%0d: got %b want 1111", i, q); end
      end
   endtask

   task automatic test_count_down();
      tick(1'b1, 1'b0);
      en = 1'b1; #1;
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL tc_at_15: got %b want 0", tc); end
      for (int i = 1; i <= 15; i++) begin
         tick(1'b0, 1'b1);
         checks++;
         if (q !== 4'(15 - i) || tc !== ((15 - i) == 0)) begin
            errors++;
            $display("FAIL count_down_%0d: got q=%b tc=%b want q=%b tc=%b",
                     i, q, tc, 4'(15 - i), (15 - i) == 0);
         end
      end
   endtask

   task automatic test_wrap();
      tick(1'b0, 1'b1);
`ifdef DOWNCOUNTER_SYNC_SATURATE_EN
      checks++;
      if (q !== 4'b0000 || tc !== 1'b1) begin
         errors++; $display("FAIL saturate: got q=%b tc=%b want q=0000 tc=1", q, tc);
      end
`else
      checks++;
      if (q !== 4'b1111 || tc !== 1'b0) begin
         errors++; $display("FAIL wrap: got q=%b tc=%b want q=1111 tc=0", q, tc);
      end
`endif
   endtask

   task automatic test_enable_gating();
      tick(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);  // 15 -> 10
      checks++;
      if (q !== 4'b1010) begin errors++; $display("FAIL gate_setup: got %b want 1010", q); end
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
      checks++;
      if (q !== 4'b1010) begin errors++; $display("FAIL gate_hold: got %b want 1010", q); end
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (q !== 4'b1000) begin errors++; $display("FAIL gate_resume: got %b want 1000", q); end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);  // 15 -> 6
      checks++;
      if (q !== 4'b0110) begin errors++; $display("FAIL areset_setup: got %b want 0110", q); end
      #2;
      rst = 1'b0;
      #1;
      m_q = 0;
      checks++;
      if (q !== 4'b0000) begin errors++; $display("FAIL areset_immediate: got %b want 0000", q); end
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1);
         checks++;
         if (q !== 4'b0000 || tc !== 1'b1) begin
            errors++; $display("FAIL areset_hold_%0d: got q=%b tc=%b want q=0000 tc=1", i, q, tc);
         end
      end
      rst = 1'b1;
      tick(1'b0, 1'b1);
      checks++;
      if (q !== 4'(m_q)) begin errors++; $display("FAIL areset_resume: got %b want %b", q, 4'(m_q)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            #2;
            rst = 1'b0;
            #1;
            m_q = 0;
            checks++;
            if (q !== 4'd0) begin errors++; $display("FAIL rand_reset_%0d: got %b want 0", i, q); end
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            rst = 1'b1;
         end
         tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 1) == 1);
         #1;
         checks++;
         if (q !== 4'(m_q) || tc !== model_tc(m_q, en)) begin
            errors++;
            $display("FAIL rand_%0d: got q=%b tc=%b want q=%b tc=%b",
                     i, q, tc, 4'(m_q), model_tc(m_q, en));
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_load_priority();
      test_count_down();
      test_wrap();
      test_enable_gating();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
